pipe_adder: RTL and testbench



---
 rtl/adder_pkg.sv | 16 +
 rtl/pipe_adder_if.sv | 40 ++++
 rtl/adder_slice.sv | 35 +++
 rtl/full_adder.sv | 12 +
 rtl/pipe_adder.sv | 135 +++++++++++++
 tb/tb_pipe_adder.sv | 274 +++++++++++++++++++++++++++
 6 files changed

// File: rtl/adder_pkg.sv
// rtl/adder_pkg.sv - shared helpers for the pipelined adder
// Purpose: slice-width computation and signed-overflow helper used by pipe_adder.
// Ports: none (package).
package adder_pkg;

  // Bits handled by each pipeline stage.
  function automatic int chunk_of(input int width, input int stages);
    return width / stages;
  endfunction

  // Signed overflow: carry into the MSB disagrees with carry out of it.
  function automatic logic ovf_of(input logic c_into_msb, input logic c_out_msb);
    return c_into_msb ^ c_out_msb;
  endfunction

endpackage

// File: rtl/pipe_adder_if.sv
// rtl/pipe_adder_if.sv - operand/result handshake bundle for pipe_adder
// Purpose: groups the input and output valid/ready streams of the adder.
// Signals: in_valid/in_ready/a/b/cin (operand side), out_valid/out_ready/sum/cout/ovf (result side).
// Macro PIPE_ADDER_SUB_EN adds the 1-bit 'sub' operand-side signal.
// Modports: master drives operands and accepts results; slave is the adder.
interface pipe_adder_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
`ifdef PIPE_ADDER_SUB_EN
  logic             sub;
`endif
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  modport master (
    output in_valid, a, b, cin,
`ifdef PIPE_ADDER_SUB_EN
    output sub,
`endif
    output out_ready,
    input  in_ready, out_valid, sum, cout, ovf
  );

  modport slave (
    input  in_valid, a, b, cin,
`ifdef PIPE_ADDER_SUB_EN
    input  sub,
`endif
    input  out_ready,
    output in_ready, out_valid, sum, cout, ovf
  );
endinterface

// File: rtl/adder_slice.sv
// rtl/adder_slice.sv - combinational CHUNK-bit ripple adder from full_adder cells
// Ports: a_i, b_i (CHUNK bits), c_i carry in; sum_o (CHUNK bits), cout_o carry out
//        of the slice MSB, cmsb_o carry into the slice MSB.
module adder_slice #(
  parameter int CHUNK = 8
) (
  input  logic [CHUNK-1:0] a_i,
  input  logic [CHUNK-1:0] b_i,
  input  logic             c_i,
  output logic [CHUNK-1:0] sum_o,
  output logic             cout_o,
  output logic             cmsb_o
);
  // Each bit keeps its own carry nets so the ripple chain is not one
  // self-referencing vector.
  for (genvar i = 0; i < CHUNK; i++) begin : g_bit
    logic ci;
    logic co;
    if (i == 0) begin : g_lsb
      assign ci = c_i;
    end else begin : g_up
      assign ci = g_bit[i-1].co;
    end
    full_adder u_fa (
      .a_i (a_i[i]),
      .b_i (b_i[i]),
      .c_i (ci),
      .s_o (sum_o[i]),
      .c_o (co)
    );
  end

  assign cout_o = g_bit[CHUNK-1].co;
  assign cmsb_o = g_bit[CHUNK-1].ci;
endmodule

// File: rtl/full_adder.sv
// rtl/full_adder.sv - single-bit full adder cell
// Ports: a_i, b_i, c_i (inputs); s_o sum bit, c_o carry out.
module full_adder (
  input  logic a_i,
  input  logic b_i,
  input  logic c_i,
  output logic s_o,
  output logic c_o
);
  assign s_o = a_i ^ b_i ^ c_i;
  assign c_o = (a_i & b_i) | (c_i & (a_i ^ b_i));
endmodule

// File: rtl/pipe_adder.sv
// rtl/pipe_adder.sv - pipelined ripple-carry adder with valid/ready streams
// Purpose: WIDTH-bit a+b+cin split into STAGES slices, one slice per stage,
//          carry registered between stages; latency STAGES, one result/cycle.
// Ports: clk, rst (async, active-high); bus (pipe_adder_if.slave) carrying
//        in_valid/in_ready/a/b/cin and out_valid/out_ready/sum/cout/ovf.
// Macro PIPE_ADDER_SUB_EN: enables bus.sub; sub=1 computes a-b (cin ignored).
module pipe_adder
  import adder_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4
) (
  input logic          clk,
  input logic          rst,
  pipe_adder_if.slave  bus
);
  localparam int CHUNK = chunk_of(WIDTH, STAGES);

  if (STAGES < 1 || STAGES > WIDTH || (WIDTH % STAGES) != 0) begin : g_bad_cfg
    $error("pipe_adder: WIDTH must be a multiple of STAGES with 1 <= STAGES <= WIDTH");
  end

  typedef struct packed {
    logic             valid;
    logic             carry;
    logic [WIDTH-1:0] sum;    // completed low bits, zeros above
    logic [WIDTH-1:0] a_rem;  // unconsumed operand bits, next slice at bit 0
    logic [WIDTH-1:0] b_rem;
  } stage_t;

  logic [STAGES-1:0] v;
  logic [STAGES-1:0] adv;
  logic [WIDTH-1:0]  b_eff;
  logic              cin_eff;
  logic              ovf_q;

`ifdef PIPE_ADDER_SUB_EN
  // Subtract as a + ~b + 1; inversion covers the whole operand at capture.
  assign b_eff   = bus.sub ? ~bus.b : bus.b;
  assign cin_eff = bus.sub | bus.cin;
`else
  assign b_eff   = bus.b;
  assign cin_eff = bus.cin;
`endif

  // A stage may load when it is empty or its content moves on this cycle.
  always_comb begin
    adv = '0;
    adv[STAGES-1] = bus.out_ready | ~v[STAGES-1];
    for (int k = STAGES - 2; k >= 0; k--) begin
      adv[k] = adv[k+1] | ~v[k];
    end
  end

  assign bus.in_ready = adv[0];

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int LO = k * CHUNK;

    stage_t           st_q;
    stage_t           st_d;
    logic             up_v;
    logic             up_c;
    logic [WIDTH-1:0] up_sum;
    logic [WIDTH-1:0] up_a;
    logic [WIDTH-1:0] up_b;
    logic [CHUNK-1:0] sl_sum;
    logic             sl_cout;
    logic             sl_cmsb;

    if (k == 0) begin : g_head
      assign up_v   = bus.in_valid;
      assign up_c   = cin_eff;
      assign up_sum = '0;
      assign up_a   = bus.a;
      assign up_b   = b_eff;
    end else begin : g_body
      assign up_v   = g_stage[k-1].st_q.valid;
      assign up_c   = g_stage[k-1].st_q.carry;
      assign up_sum = g_stage[k-1].st_q.sum;
      assign up_a   = g_stage[k-1].st_q.a_rem;
      assign up_b   = g_stage[k-1].st_q.b_rem;
    end

    adder_slice #(.CHUNK(CHUNK)) u_slice (
      .a_i    (up_a[CHUNK-1:0]),
      .b_i    (up_b[CHUNK-1:0]),
      .c_i    (up_c),
      .sum_o  (sl_sum),
      .cout_o (sl_cout),
      .cmsb_o (sl_cmsb)
    );

    always_comb begin
      st_d       = '0;
      st_d.valid = up_v;
      st_d.carry = sl_cout;
      st_d.sum   = up_sum | (WIDTH'(sl_sum) << LO);
      st_d.a_rem = up_a >> CHUNK;
      st_d.b_rem = up_b >> CHUNK;
    end

    // Data only captured with a valid upstream item, so bubbles never
    // overwrite held data and idle operand buses never reach the registers.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        st_q <= '0;
      end else if (adv[k]) begin
        st_q.valid <= st_d.valid;
        if (up_v) begin
          st_q.carry <= st_d.carry;
          st_q.sum   <= st_d.sum;
          st_q.a_rem <= st_d.a_rem;
          st_q.b_rem <= st_d.b_rem;
        end
      end
    end

    assign v[k] = st_q.valid;
  end

  // The last slice's MSB is the word MSB, so its carries give the overflow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_q <= 1'b0;
    end else if (adv[STAGES-1] && g_stage[STAGES-1].up_v) begin
      ovf_q <= ovf_of(g_stage[STAGES-1].sl_cmsb, g_stage[STAGES-1].sl_cout);
    end
  end

  assign bus.out_valid = v[STAGES-1];
  assign bus.sum       = g_stage[STAGES-1].st_q.sum;
  assign bus.cout      = g_stage[STAGES-1].st_q.carry;
  assign bus.ovf       = ovf_q;
endmodule

// File: tb/tb_pipe_adder.sv
// tb/tb_pipe_adder.sv - directed self-checking bench for pipe_adder
module tb_pipe_adder;
  localparam int W = 32;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        cin;
    logic        sub;
    logic [31:0] s;
    logic        c;
    logic        o;
  } vec_t;

  typedef struct {
    logic [31:0] s;
    logic        c;
    logic        o;
    int          t;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  int          cyc = 0;
  int          n_checks = 0;
  int          n_pass = 0;

  logic        d_valid, d_cin, d_sub, d_rdy, d_ec, d_eo;
  logic [31:0] d_a, d_b, d_es;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  pipe_adder_if #(.WIDTH(W)) if0 ();
  pipe_adder_if #(.WIDTH(W)) if1 ();
  pipe_adder_if #(.WIDTH(W)) if2 ();

  pipe_adder #(.WIDTH(W), .STAGES(4))  u_dut  (.clk(clk), .rst(rst), .bus(if0));
  pipe_adder #(.WIDTH(W), .STAGES(1))  u_dut1 (.clk(clk), .rst(rst), .bus(if1));
  pipe_adder #(.WIDTH(W), .STAGES(W))  u_dutw (.clk(clk), .rst(rst), .bus(if2));

  // Main instance sees the bench handshake; the others accept exactly when
  // the main one does and never stall their outputs.
  assign if0.in_valid = d_valid;
  assign if1.in_valid = d_valid & if0.in_ready;
  assign if2.in_valid = d_valid & if0.in_ready;
  assign {if0.a, if0.b, if0.cin} = {d_a, d_b, d_cin};
  assign {if1.a, if1.b, if1.cin} = {d_a, d_b, d_cin};
  assign {if2.a, if2.b, if2.cin} = {d_a, d_b, d_cin};
  assign if0.out_ready = d_rdy;
  assign if1.out_ready = 1'b1;
  assign if2.out_ready = 1'b1;
`ifdef PIPE_ADDER_SUB_EN
  assign if0.sub = d_sub;
  assign if1.sub = d_sub;
  assign if2.sub = d_sub;
`endif

  logic        ov[3], ordy[3], ival[3], irdy[3], co[3], of[3];
  logic [31:0] sm[3];
  assign {ov[0], ordy[0], ival[0], irdy[0], co[0], of[0], sm[0]} =
         {if0.out_valid, if0.out_ready, if0.in_valid, if0.in_ready, if0.cout, if0.ovf, if0.sum};
  assign {ov[1], ordy[1], ival[1], irdy[1], co[1], of[1], sm[1]} =
         {if1.out_valid, if1.out_ready, if1.in_valid, if1.in_ready, if1.cout, if1.ovf, if1.sum};
  assign {ov[2], ordy[2], ival[2], irdy[2], co[2], of[2], sm[2]} =
         {if2.out_valid, if2.out_ready, if2.in_valid, if2.in_ready, if2.cout, if2.ovf, if2.sum};

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Per-instance in-order scoreboard of the hand-computed expectations.
  for (genvar g = 0; g < 3; g++) begin : g_sb
    localparam int STG = (g == 0) ? 4 : (g == 1) ? 1 : W;
    exp_t q[$];
    always begin
      exp_t e;
      @(negedge clk);
      if (rst) begin
        q.delete();
      end else begin
        if (ov[g] && ordy[g]) begin
          if (q.size() == 0) begin
            check($sformatf("sb%0d_spurious", g), 64'(ov[g]), 64'd0);
          end else begin
            e = q.pop_front();
            check($sformatf("sb%0d_sum", g), 64'(sm[g]), 64'(e.s));
            check($sformatf("sb%0d_cout", g), 64'(co[g]), 64'(e.c));
            check($sformatf("sb%0d_ovf", g), 64'(of[g]), 64'(e.o));
            if (g != 0) check($sformatf("sb%0d_lat", g), 64'(cyc - e.t), 64'(STG - 1));
          end
        end
        if (ival[g] && irdy[g]) q.push_back('{s: d_es, c: d_ec, o: d_eo, t: cyc + 1});
      end
    end
  end

  function automatic vec_t mk(input logic [31:0] a, input logic [31:0] b, input logic cin,
                              input logic sub, input logic [31:0] s, input logic c, input logic o);
    vec_t v;
    v.a = a; v.b = b; v.cin = cin; v.sub = sub; v.s = s; v.c = c; v.o = o;
    return v;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input vec_t v);
    d_a = v.a; d_b = v.b; d_cin = v.cin; d_sub = v.sub;
    d_es = v.s; d_ec = v.c; d_eo = v.o;
    d_valid = 1'b1;
  endtask

  task automatic run_single(input string tag, input vec_t v);
    int lat;
    d_rdy = 1'b1;
    drive(v);
    check({tag, "_in_ready"}, 64'(if0.in_ready), 64'd1);
    tick;
    d_valid = 1'b0;
    lat = 1;
    while (!if0.out_valid && lat < 40) begin
      tick;
      lat++;
    end
    check({tag, "_lat"}, 64'(lat), 64'd4);
    check({tag, "_sum"}, 64'(if0.sum), 64'(v.s));
    check({tag, "_cout"}, 64'(if0.cout), 64'(v.c));
    check({tag, "_ovf"}, 64'(if0.ovf), 64'(v.o));
  endtask

  vec_t strm[8];
  vec_t stl[6];
  vec_t rv[3];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int first, last, cnt, acc, idx, bound;
    logic ir;

    strm[0] = mk(32'h00000001, 32'h00000002, 1'b0, 1'b0, 32'h00000003, 1'b0, 1'b0);
    strm[1] = mk(32'h12345678, 32'h11111111, 1'b1, 1'b0, 32'h2345678A, 1'b0, 1'b0);
    strm[2] = mk(32'h80000000, 32'h80000000, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b1);
    strm[3] = mk(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b0, 32'hFFFFFFFF, 1'b1, 1'b0);
    strm[4] = mk(32'h0000FFFF, 32'h00000001, 1'b0, 1'b0, 32'h00010000, 1'b0, 1'b0);
    strm[5] = mk(32'h40000000, 32'h40000000, 1'b0, 1'b0, 32'h80000000, 1'b0, 1'b1);
    strm[6] = mk(32'hDEADBEEF, 32'h00000000, 1'b1, 1'b0, 32'hDEADBEF0, 1'b0, 1'b0);
    strm[7] = mk(32'hA5A5A5A5, 32'h5A5A5A5A, 1'b0, 1'b0, 32'hFFFFFFFF, 1'b0, 1'b0);
    stl[0]  = mk(32'h00000010, 32'h00000020, 1'b0, 1'b0, 32'h00000030, 1'b0, 1'b0);
    stl[1]  = mk(32'h0F0F0F0F, 32'hF0F0F0F0, 1'b1, 1'b0, 32'h00000000, 1'b1, 1'b0);
    stl[2]  = mk(32'h00000100, 32'h00000200, 1'b1, 1'b0, 32'h00000301, 1'b0, 1'b0);
    stl[3]  = mk(32'h7FFFFFFF, 32'h7FFFFFFF, 1'b1, 1'b0, 32'hFFFFFFFF, 1'b0, 1'b1);
    stl[4]  = mk(32'h00000005, 32'h00000006, 1'b0, 1'b0, 32'h0000000B, 1'b0, 1'b0);
    stl[5]  = mk(32'h11111111, 32'h22222222, 1'b0, 1'b0, 32'h33333333, 1'b0, 1'b0);
    rv[0]   = mk(32'h00000001, 32'h00000001, 1'b0, 1'b0, 32'h00000002, 1'b0, 1'b0);
    rv[1]   = mk(32'h00000002, 32'h00000002, 1'b0, 1'b0, 32'h00000004, 1'b0, 1'b0);
    rv[2]   = mk(32'h00000003, 32'h00000003, 1'b0, 1'b0, 32'h00000006, 1'b0, 1'b0);

    d_valid = 1'b0; d_a = '0; d_b = '0; d_cin = 1'b0; d_sub = 1'b0;
    d_rdy = 1'b1; d_es = '0; d_ec = 1'b0; d_eo = 1'b0;

    // Reset state
    #2;
    check("rst_out_valid", 64'(if0.out_valid), 64'd0);
    check("rst_sum", 64'(if0.sum), 64'd0);
    check("rst_cout", 64'(if0.cout), 64'd0);
    check("rst_ovf", 64'(if0.ovf), 64'd0);
    tick;
    tick;
    rst = 1'b0;
    #1;
    check("rst_in_ready", 64'(if0.in_ready), 64'd1);

    // Single-operand boundaries
    run_single("wrap", mk(32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b0));
    run_single("sovf", mk(32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h80000000, 1'b0, 1'b1));

    // Back-to-back stream at full throughput
    d_rdy = 1'b1;
    first = -1; last = -1; cnt = 0;
    for (int j = 0; j < 28; j++) begin
      if (j < 8) begin
        drive(strm[j]);
        check($sformatf("b2b_in_ready_%0d", j), 64'(if0.in_ready), 64'd1);
      end else begin
        d_valid = 1'b0;
      end
      tick;
      if (if0.out_valid) begin
        cnt++;
        if (first < 0) first = j;
        last = j;
      end
    end
    check("b2b_count", 64'(cnt), 64'd8);
    check("b2b_span", 64'(last - first), 64'd7);
    check("b2b_first", 64'(first), 64'd3);

    // Fill with output stalled, hold, then release
    d_rdy = 1'b0;
    acc = 0; idx = 0;
    for (int c = 0; c < 9; c++) begin
      drive(stl[idx]);
      ir = if0.in_ready;
      tick;
      if (ir) begin
        idx++;
        acc++;
      end
      if (c >= 3) begin
        check($sformatf("stall_valid_%0d", c), 64'(if0.out_valid), 64'd1);
        check($sformatf("stall_sum_%0d", c), 64'(if0.sum), 64'h30);
        check($sformatf("stall_in_ready_%0d", c), 64'(if0.in_ready), 64'd0);
      end
    end
    check("stall_accepts", 64'(acc), 64'd4);
    d_rdy = 1'b1;
    bound = 0;
    while (idx < 6 && bound < 20) begin
      drive(stl[idx]);
      ir = if0.in_ready;
      tick;
      if (ir) idx++;
      bound++;
    end
    check("stall_release_done", 64'(idx), 64'd6);
    d_valid = 1'b0;
    repeat (10) tick;

    // Reset with three items in flight
    d_rdy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(rv[i]);
      tick;
    end
    d_valid = 1'b0;
    rst = 1'b1;
    #1;
    check("mid_rst_out_valid", 64'(if0.out_valid), 64'd0);
    check("mid_rst_sum", 64'(if0.sum), 64'd0);
    check("mid_rst_cout", 64'(if0.cout), 64'd0);
    check("mid_rst_ovf", 64'(if0.ovf), 64'd0);
    tick;
    tick;
    rst = 1'b0;
    run_single("post_rst", mk(32'h00000009, 32'h00000001, 1'b0, 1'b0, 32'h0000000A, 1'b0, 1'b0));

`ifdef PIPE_ADDER_SUB_EN
    run_single("sub_neg", mk(32'h00000005, 32'h00000007, 1'b0, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0));
    run_single("sub_pos", mk(32'h00000007, 32'h00000005, 1'b1, 1'b1, 32'h00000002, 1'b1, 1'b0));
    run_single("sub_ovf", mk(32'h80000000, 32'h00000001, 1'b0, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b1));
    d_sub = 1'b0;
`endif

    // Drain every instance, nothing may be left outstanding
    d_valid = 1'b0;
    repeat (40) tick;
    check("sb0_drain", 64'(g_sb[0].q.size()), 64'd0);
    check("sb1_drain", 64'(g_sb[1].q.size()), 64'd0);
    check("sb2_drain", 64'(g_sb[2].q.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
